// File: rtl/pc_update.sv
// Program-counter register with next-PC selection for jXX/call/ret/sequential flow.
// Optional build macro PC_UPDATE_HALT_EN: when defined, icode 4'h0 (halt) freezes pc.
module pc_update #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  icode,
   input  logic [63:0] valC,
   input  logic [63:0] valP,
   input  logic [63:0] valM,
   input  logic        cnd,
   output logic [63:0] pc
);

   localparam logic [3:0] ICODE_HALT = 4'h0;
   localparam logic [3:0] ICODE_JXX  = 4'h7;
   localparam logic [3:0] ICODE_CALL = 4'h8;
   localparam logic [3:0] ICODE_RET  = 4'h9;

   logic [63:0] r_pc;
   logic [63:0] w_next_pc;

   always_comb begin
      w_next_pc = valP;
      case (icode)
         ICODE_JXX:  w_next_pc = cnd ? valC : valP;
         ICODE_CALL: w_next_pc = valC;
         ICODE_RET:  w_next_pc = valM;
`ifdef PC_UPDATE_HALT_EN
         ICODE_HALT: w_next_pc = r_pc;
`else
         ICODE_HALT: w_next_pc = valP;
`endif
         default:    w_next_pc = valP;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc <= RESET_PC;
      end else begin
         r_pc <= w_next_pc;
      end
   end

   assign pc = r_pc;

endmodule

// File: tb/tb_pc_update.sv
// Directed-vector bench for pc_update: reset, branch/call/ret/default selection, halt, async reset.
module tb_pc_update;

`ifdef PC_UPDATE_HALT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   typedef struct {
      logic [3:0]  icode;
      logic        cnd;
      logic [63:0] valC;
      logic [63:0] valP;
      logic [63:0] valM;
      logic [63:0] exp_pc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  icode = 4'h0;
   logic [63:0] valC = 64'h0;
   logic [63:0] valP = 64'h0;
   logic [63:0] valM = 64'h0;
   logic        cnd = 1'b0;
   logic [63:0] pc;

   int passed = 0;
   int total = 0;

   pc_update #(.RESET_PC(64'h0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .icode (icode),
      .valC  (valC),
      .valP  (valP),
      .valM  (valM),
      .cnd   (cnd),
      .pc    (pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total = total + 1;
      if (act === exp) begin
         passed = passed + 1;
         $display("ok   %s pc=%h", name, act);
      end else begin
         $display("FAIL %s pc=%h expected=%h", name, act, exp);
      end
   endtask

   vec_t vecs[15];

   initial begin
      logic [63:0] prev_pc;
      logic [63:0] halt_a;
      logic [63:0] halt_b;
      halt_a = HALT_EN ? 64'h50 : 64'h70;
      halt_b = HALT_EN ? 64'h50 : 64'h80;
      vecs[0]  = '{4'h7, 1'b1, 64'h20, 64'h10, 64'h0, 64'h20};
      vecs[1]  = '{4'h7, 1'b0, 64'h20, 64'h10, 64'h0, 64'h10};
      vecs[2]  = '{4'h8, 1'b0, 64'h30, 64'h0, 64'h0, 64'h30};
      vecs[3]  = '{4'h9, 1'b0, 64'h0, 64'h0, 64'h40, 64'h40};
      vecs[4]  = '{4'h2, 1'b0, 64'h0, 64'h50, 64'h0, 64'h50};
      vecs[5]  = '{4'hF, 1'b0, 64'h0, 64'h60, 64'h0, 64'h60};
      vecs[6]  = '{4'h2, 1'b1, 64'h11, 64'h50, 64'h22, 64'h50};
      vecs[7]  = '{4'h0, 1'b0, 64'h0, 64'h70, 64'h0, halt_a};
      vecs[8]  = '{4'h0, 1'b1, 64'h5, 64'h80, 64'h6, halt_b};
      vecs[9]  = '{4'h8, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[10] = '{4'h9, 1'b1, 64'h3, 64'h4, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001};
      vecs[11] = '{4'h4, 1'b1, 64'h99, 64'hFFFF_FFFF_FFFF_FFFF, 64'h77, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[12] = '{4'hC, 1'b1, 64'hAA, 64'hC0, 64'hBB, 64'hC0};
      vecs[13] = '{4'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h8, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE};
      vecs[14] = '{4'h9, 1'b0, 64'h1, 64'h2, 64'h40, 64'h40};

      // Reset asserted with arbitrary inputs, before any clock edge.
      icode = 4'h8; valC = 64'hDEAD_BEEF; valP = 64'h1234; valM = 64'h5678; cnd = 1'b1;
      #1 rst_n = 1'b0;
      #1 check("reset_no_edge", pc, 64'h0);
      @(posedge clk); #1;
      check("reset_held_over_edge", pc, 64'h0);
      @(negedge clk);
      icode = 4'hF; valP = 64'h0; rst_n = 1'b1;
      @(posedge clk); #1;
      check("reset_release_valP0", pc, 64'h0);

      prev_pc = 64'h0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         icode = vecs[i].icode; cnd = vecs[i].cnd;
         valC = vecs[i].valC; valP = vecs[i].valP; valM = vecs[i].valM;
         #1 check($sformatf("vec%0d_pre_edge", i), pc, prev_pc);
         @(posedge clk); #1;
         check($sformatf("vec%0d_icode%h", i, vecs[i].icode), pc, vecs[i].exp_pc);
         prev_pc = vecs[i].exp_pc;
      end

      // Asynchronous reset pulsed between edges while pc=0x40.
      @(negedge clk);
      icode = 4'h8; valC = 64'h123;
      #2 rst_n = 1'b0;
      #1 check("async_reset_immediate", pc, 64'h0);
      #1 rst_n = 1'b1;
      #1 check("async_reset_still_low_pc", pc, 64'h0);
      @(posedge clk); #1;
      check("after_async_release", pc, 64'h123);

      // Reset held across an edge discards the pending update.
      @(negedge clk);
      icode = 4'h7; cnd = 1'b1; valC = 64'h444; valP = 64'h555;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("reset_discards_update", pc, 64'h0);
      @(negedge clk);
      rst_n = 1'b1; cnd = 1'b0;
      @(posedge clk); #1;
      check("first_edge_after_release", pc, 64'h555);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pc_update.md
PC_UPDATE -- requirements
Module: pc_update

Interface
REQ-001 Parameter RESET_PC, default 64'h0, the value loaded into pc on reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 icode  input  4  instruction code of the current instruction.
REQ-005 valC  input  64  constant word (jump or call target).
REQ-006 valP  input  64  address of the sequentially next instruction.
REQ-007 valM  input  64  word read from memory (return address for ret).
REQ-008 cnd  input  1  branch condition from the execute stage; 1 = taken.
REQ-009 pc  output  64  registered program counter.

Function
REQ-010 Next-PC selection is combinational; pc loads the selected value on every rising clk edge while rst_n=1.
REQ-011 Latency is one edge: a change to icode, cnd, valC, valP or valM appears on pc after the next rising edge and never earlier.
REQ-012 icode=4'h7 (jXX): next pc = valC when cnd=1, and valP when cnd=0.
REQ-013 icode=4'h8 (call): next pc = valC, irrespective of cnd.
REQ-014 icode=4'h9 (ret): next pc = valM, irrespective of cnd.
REQ-015 Every other icode, including undefined codes 4'hC-4'hF: next pc = valP, except icode=4'h0 when PC_UPDATE_HALT_EN is defined (REQ-022).
REQ-016 cnd is ignored for every icode other than 4'h7.
REQ-017 All values are full 64-bit unsigned with no arithmetic, alignment check, truncation or sign extension; 64'hFFFF_FFFF_FFFF_FFFF passes unchanged.
REQ-018 The pc output is driven directly from the register, with no combinational path from any input to pc.

Reset
REQ-019 rst_n=0 forces pc to RESET_PC immediately, without waiting for a clock edge.
REQ-020 pc holds RESET_PC while rst_n=0.
REQ-021 After rst_n is released, the first rising edge loads the next-pc value selected from the inputs at that edge. Reset asserted mid-operation discards any pending update.

Configuration
REQ-022 Macro PC_UPDATE_HALT_EN defined: icode=4'h0 (halt) holds pc at its current value on every edge until icode changes or reset is asserted.
REQ-023 Macro PC_UPDATE_HALT_EN undefined: icode=4'h0 follows REQ-015, so next pc = valP.

Verification
REQ-024 Reset: rst_n=0 with arbitrary inputs -> pc=64'h0 with no clock edge; inputs icode=F, valP=0, then rst_n released -> pc stays 64'h0.
REQ-025 Jump: icode=7, valC=64'h20, valP=64'h10; cnd=1 -> pc=64'h20 after one edge; cnd=0 -> pc=64'h10 after the next edge.
REQ-026 Call and ret: icode=8, valC=64'h30, cnd=0 -> pc=64'h30; then icode=9, valM=64'h40 -> pc=64'h40.
REQ-027 Default path: icode=2, valP=64'h50 -> pc=64'h50; icode=F, valP=64'h60 -> pc=64'h60.
REQ-028 Halt: pc=64'h50, icode=0, valP=64'h70 -> pc stays 64'h50 with PC_UPDATE_HALT_EN defined, and becomes 64'h70 without it.
REQ-029 Asynchronous reset mid-run: pc=64'h40, rst_n pulsed low between edges -> pc=64'h0 immediately; the first edge after release loads the selected next-pc value.
